// File: rtl/fp_div.sv
// Sequential IEEE-754 single-precision divider (operand_a / operand_b) using a
// radix-2 restoring mantissa iteration with start/busy/done handshake.
module fp_div #(
  parameter logic [31:0] NAN_VALUE = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        dz
);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

  state_t      state;
  logic [31:0] a_lat;
  logic [31:0] b_lat;
  logic [24:0] rem;
  logic [25:0] q;
  logic [4:0]  count;

  // One restoring step: remainder is one bit wider than the divisor mantissa.
  logic [24:0] mb;
  logic        ge;
  logic [24:0] rem_sub;
  logic [24:0] rem_next;

  assign mb       = {2'b01, b_lat[22:0]};
  assign ge       = (rem >= mb);
  assign rem_sub  = ge ? (rem - mb) : rem;
  assign rem_next = rem_sub << 1;

  logic        sa, sb, s;
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {sa, ea, fa} = a_lat;
  assign {sb, eb, fb} = b_lat;
  assign s      = sa ^ sb;
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

  logic [22:0]       mant;
  logic              guard, sticky, rnd;
  logic [23:0]       mant_sum;
  logic signed [9:0] exp_base, exp_r;
  logic [31:0]       normal_res;
  logic [31:0]       res_c;
  logic              dz_c;

  always_comb begin
    mant     = q[23:1];
    guard    = q[0];
    sticky   = (rem != 25'd0);
    exp_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd126;
    if (q[25]) begin
      mant     = q[24:2];
      guard    = q[1];
      sticky   = q[0] | (rem != 25'd0);
      exp_base = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
    end
    rnd      = guard & (sticky | mant[0]);
    mant_sum = {1'b0, mant} + {23'd0, rnd};
    exp_r    = exp_base + $signed({9'd0, mant_sum[23]});
    if (exp_r >= 10'sd255)
      normal_res = {s, 8'hFF, 23'd0};
    else if (exp_r <= 10'sd0)
      normal_res = {s, 31'd0};
    else
      normal_res = {s, exp_r[7:0], mant_sum[22:0]};
  end

  // Special-case priority: NaN in, invalid, inf/x, x/0, zero result.
  always_comb begin
    res_c = normal_res;
    dz_c  = 1'b0;
    if (a_nan || b_nan)
      res_c = NAN_VALUE;
    else if ((a_zero && b_zero) || (a_inf && b_inf))
      res_c = NAN_VALUE;
    else if (a_inf)
      res_c = {s, 8'hFF, 23'd0};
    else if (b_zero) begin
      res_c = {s, 8'hFF, 23'd0};
      dz_c  = 1'b1;
    end else if (a_zero || b_inf)
      res_c = {s, 31'd0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      result <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      dz     <= 1'b0;
      count  <= 5'd0;
      a_lat  <= 32'd0;
      b_lat  <= 32'd0;
      rem    <= 25'd0;
      q      <= 26'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_lat <= operand_a;
            b_lat <= operand_b;
            rem   <= {2'b01, operand_a[22:0]};
            q     <= 26'd0;
            count <= 5'd25;
            busy  <= 1'b1;
            state <= DIVIDE;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DIVIDE: begin
          q   <= {q[24:0], ge};
          rem <= rem_next;
          if (count == 5'd0)
            state <= NORM;
          else
            count <= count - 5'd1;
        end
        NORM: begin
          result <= res_c;
          dz     <= dz_c;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// Self-checking bench for fp_div: directed cases, random operands against an
// arithmetic reference model, handshake and reset scenarios.
module tb_fp_div;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [31:0] result;
  logic        busy;
  logic        done;
  logic        dz;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  fp_div dut (
    .clk(clk), .rst(rst), .start(start),
    .operand_a(operand_a), .operand_b(operand_b),
    .result(result), .busy(busy), .done(done), .dz(dz)
  );

  // Reference: one wide integer division of the mantissas, then exact RNE.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic d);
    logic sa, sb, s;
    int ea, eb, e, sh;
    logic [22:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    longint unsigned ma, mb, num, qq, rr, m, low, half;
    sa = a[31]; sb = b[31]; s = sa ^ sb;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0]; fb = b[22:0];
    a_zero = (ea == 0); b_zero = (eb == 0);
    a_inf = (ea == 255) && (fa == 0); b_inf = (eb == 255) && (fb == 0);
    a_nan = (ea == 255) && (fa != 0); b_nan = (eb == 255) && (fb != 0);
    d = 1'b0;
    r = 32'd0;
    if (a_nan || b_nan) r = 32'h7FC00000;
    else if ((a_zero && b_zero) || (a_inf && b_inf)) r = 32'h7FC00000;
    else if (a_inf) r = {s, 8'hFF, 23'd0};
    else if (b_zero) begin r = {s, 8'hFF, 23'd0}; d = 1'b1; end
    else if (a_zero || b_inf) r = {s, 31'd0};
    else begin
      ma = 64'h800000 | 64'(fa);
      mb = 64'h800000 | 64'(fb);
      num = ma << 39;
      qq = num / mb;
      rr = num % mb;
      if (qq >= (64'd1 << 39)) begin sh = 16; e = ea - eb + 127; end
      else begin sh = 15; e = ea - eb + 126; end
      m = qq >> sh;
      low = qq & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (low > half || (low == half && (rr != 0 || m[0]))) m = m + 64'd1;
      if (m == (64'd1 << 24)) begin m = m >> 1; e = e + 1; end
      if (e >= 255) r = {s, 8'hFF, 23'd0};
      else if (e <= 0) r = {s, 31'd0};
      else r = {s, e[7:0], m[22:0]};
    end
  endfunction

  function automatic logic [31:0] gen_op();
    logic [31:0] v;
    logic [7:0] ex;
    v = $urandom;
    case ($urandom_range(0, 4))
      0: ex = v[30:23];
      1: ex = 8'($urandom_range(110, 144));
      2: begin
        case ($urandom_range(0, 4))
          0: ex = 8'd0;
          1: ex = 8'd255;
          2: ex = 8'd1;
          3: ex = 8'd254;
          default: ex = 8'd127;
        endcase
        if ($urandom_range(0, 1) == 0) v[22:0] = 23'd0;
      end
      3: ex = 8'($urandom_range(1, 254));
      default: ex = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(1, 20))
                                                : 8'($urandom_range(235, 254));
    endcase
    v[30:23] = ex;
    return v;
  endfunction

  function automatic logic [31:0] gen_normal();
    logic [31:0] v;
    v = $urandom;
    v[30:23] = 8'($urandom_range(100, 154));
    return v;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0; operand_a = $urandom; operand_b = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; operand_a = 32'd0; operand_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({busy, done, dz} !== 3'b000) $display("FAIL reset_flags busy/done/dz=%b required 000", {busy, done, dz}); else passes++;
    checks++; if (result !== 32'd0) $display("FAIL reset_result got %08h required 00000000", result); else passes++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [12] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h00000000,
                             32'h7F800000, 32'h7F7FFFFF, 32'h00800000, 32'h7FC00001, 32'h7F800000, 32'h40000000};
    logic [31:0] tb [12] = '{32'h40000000, 32'h40400000, 32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000,
                             32'h7F800000, 32'h3F000000, 32'h40000000, 32'h3F800000, 32'hC0000000, 32'hFF800000};
    logic [31:0] te [12] = '{32'h40400000, 32'h3EAAAAAB, 32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h7FC00000,
                             32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h7FC00000, 32'hFF800000, 32'h80000000};
    logic        td [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int n;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      issue(ta[i], tb[i]);
      wait_done(n);
      $display("txn directed %08h / %08h -> %08h dz=%0b edges=%0d", ta[i], tb[i], result, dz, n);
      checks++; if (n !== 27) $display("FAIL dir_latency[%0d] got %0d edges required 27", i, n); else passes++;
      checks++; if (result !== te[i]) $display("FAIL dir_result[%0d] got %08h required %08h", i, result, te[i]); else passes++;
      checks++; if (dz !== td[i]) $display("FAIL dir_dz[%0d] got %0b required %0b", i, dz, td[i]); else passes++;
      @(posedge clk); #1;
      checks++; if ({done, busy} !== 2'b00) $display("FAIL dir_done_pulse[%0d] done/busy=%b required 00", i, {done, busy}); else passes++;
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, er;
    logic ed;
    int n;
    for (int i = 0; i < 50; i++) begin
      a = gen_op(); b = gen_op();
      ref_div(a, b, er, ed);
      @(negedge clk);
      issue(a, b);
      wait_done(n);
      $display("txn random %08h / %08h -> %08h dz=%0b", a, b, result, dz);
      checks++; if (n !== 27 || result !== er || dz !== ed)
        $display("FAIL rand[%0d] %08h/%08h got %08h dz=%0b edges=%0d required %08h dz=%0b edges=27", i, a, b, result, dz, n, er, ed);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, er;
    logic ed;
    int n;
    a = gen_normal(); b = gen_normal();
    @(negedge clk);
    issue(a, b);
    for (int i = 0; i < 4; i++) begin
      ref_div(a, b, er, ed);
      wait_done(n);
      $display("txn b2b %08h / %08h -> %08h dz=%0b", a, b, result, dz);
      checks++; if (n !== 27 || result !== er) $display("FAIL b2b_result[%0d] got %08h edges=%0d required %08h edges=27", i, result, n, er); else passes++;
      a = gen_normal(); b = gen_normal();
      issue(a, b);
      checks++; if ({busy, done} !== 2'b10) $display("FAIL b2b_accept[%0d] busy/done=%b required 10", i, {busy, done}); else passes++;
    end
    wait_done(n);
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b, er;
    logic ed;
    int n;
    a = gen_normal(); b = gen_normal();
    ref_div(a, b, er, ed);
    @(negedge clk);
    issue(a, b);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; operand_a = gen_normal(); operand_b = gen_normal();
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    $display("txn busy_ignore %08h / %08h -> %08h", a, b, result);
    checks++; if (n !== 21) $display("FAIL busy_latency got %0d edges required 21", n); else passes++;
    checks++; if (result !== er) $display("FAIL busy_ignore got %08h required %08h", result, er); else passes++;
    @(posedge clk); #1;
    checks++; if ({busy, done} !== 2'b00) $display("FAIL busy_no_restart busy/done=%b required 00", {busy, done}); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] er;
    logic ed;
    logic saw_done;
    int n;
    @(negedge clk);
    issue(32'h3F800000, 32'h00000000);
    wait_done(n);
    @(negedge clk);
    issue(32'h40C00000, 32'h40000000);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if ({busy, done, dz} !== 3'b000) $display("FAIL rst_mid_flags busy/done/dz=%b required 000", {busy, done, dz}); else passes++;
    checks++; if (result !== 32'd0) $display("FAIL rst_mid_result got %08h required 00000000", result); else passes++;
    @(negedge clk); rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) $display("FAIL rst_mid_idle activity seen after abort, required none"); else passes++;
    ref_div(32'h3F800000, 32'h40400000, er, ed);
    @(negedge clk);
    issue(32'h3F800000, 32'h40400000);
    wait_done(n);
    $display("txn after_reset 3f800000 / 40400000 -> %08h", result);
    checks++; if (n !== 27 || result !== er) $display("FAIL rst_recover got %08h edges=%0d required %08h edges=27", result, n, er); else passes++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
